lane_dequant_expand: RTL and testbench

- Inverse of the stochastic-round narrowing stage on the datapath.
- Accepts packed 2-lane narrow codes over a valid/ready stream.
- Per lane: removes a programmable zero-point, re-expands to accumulator width by left-shifting WID_SHIFT, and saturates.
- Emits 2-lane wide words with per-lane saturation flags and a frame-last marker. Sits between the activation buffer read port and the accumulator/PE input.

---
 rtl/lane_dequant_expand_pkg.sv | 25 ++
 rtl/lane_dequant_expand_if.sv | 28 ++
 rtl/lane_dequant_expand_sat.sv | 25 ++
 rtl/lane_dequant_expand.sv | 113 +++++++++++
 tb/tb_lane_dequant_expand.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/lane_dequant_expand_pkg.sv
// Purpose: shared widths, saturation bounds and stage payload types for the dequant expander.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dequant_pkg;

    localparam int WID_DATA_IN  = 32;                          // wide (output) lane width
    localparam int WID_DATA_OUT = 8;                           // narrow (input) code width
    localparam int WID_SHIFT    = WID_DATA_IN - WID_DATA_OUT;  // expansion shift
    localparam int WID_LEN      = 16;                          // frame length / beat counter

    typedef logic signed [WID_DATA_OUT-1:0] lane_code_t;
    typedef logic signed [WID_DATA_IN-1:0]  lane_wide_t;
    // code minus zero-point needs one extra bit: range is -(2^N-1) .. 2^N-1
    typedef logic signed [WID_DATA_OUT:0]   lane_diff_t;

    localparam lane_wide_t SAT_MAX = {1'b0, {(WID_DATA_IN-1){1'b1}}};
    localparam lane_wide_t SAT_MIN = {1'b1, {(WID_DATA_IN-1){1'b0}}};

    typedef struct packed {
        lane_diff_t d1;
        lane_diff_t d0;
        logic       last;
    } s1_payload_t;

endpackage

// File: rtl/lane_dequant_expand_if.sv
// Purpose: input code stream and output wide stream of the dequant expander.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; slave = expander, master = its environment.
// Signals: in_valid/in_ready/in_data (2 narrow lanes, lane0 in LSBs),
//          out_valid/out_ready/out_data (2 wide lanes), out_sat (bit0 = lane0), out_last.
interface lane_dequant_expand_if;
    import dequant_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [2*WID_DATA_OUT-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*WID_DATA_IN-1:0]  out_data;
    logic [1:0]                out_sat;
    logic                      out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_last
    );

endinterface

// File: rtl/lane_dequant_expand_sat.sv
// Purpose: one lane of re-expansion: sign-extend, shift left by WID_SHIFT, saturate to wide width.
// Latency: combinational.
// Backpressure: none (pure function of d).
// Ports: d (signed difference in), w_out (saturated wide value), sat (clamp applied).
module lane_expand_sat
    import dequant_pkg::*;
(
    input  lane_diff_t d,
    output lane_wide_t w_out,
    output logic       sat
);

    // One guard bit above the wide width: overflow iff the top two bits differ.
    logic signed [WID_DATA_IN:0] w;
    logic                        pos_ovf;
    logic                        neg_ovf;

    assign w       = (WID_DATA_IN+1)'(d) <<< WID_SHIFT;
    assign pos_ovf = !w[WID_DATA_IN] &&  w[WID_DATA_IN-1];
    assign neg_ovf =  w[WID_DATA_IN] && !w[WID_DATA_IN-1];
    assign sat     = pos_ovf || neg_ovf;
    assign w_out   = pos_ovf ? SAT_MAX :
                     neg_ovf ? SAT_MIN : w[WID_DATA_IN-1:0];

endmodule

// File: rtl/lane_dequant_expand.sv
// Purpose: 2-lane dequantiser: subtract per-lane zero-point, expand to accumulator width, saturate, tag frame-last.
// Latency: 2 cycles accept-to-out_valid, 1 beat/clk; outputs held while out_valid && !out_ready.
// Backpressure: in_ready = !s1_v || !s2_v || out_ready (combinational from out_ready only).
// Ports: clk, rst_n (async active-low), io (lane_dequant_expand_if.slave),
//        cfg_we/cfg_zp0/cfg_zp1/cfg_len (config; len 0 acts as 1), zero_cnt (zero-code statistics).
// Optional: define DEQUANT_STATS_EN to build the zero-code counter; otherwise zero_cnt is tied to 0.
module lane_dequant_expand
    import dequant_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    lane_dequant_expand_if.slave io,
    input  logic               cfg_we,
    input  lane_code_t         cfg_zp0,
    input  lane_code_t         cfg_zp1,
    input  logic [WID_LEN-1:0] cfg_len,
    output logic [31:0]        zero_cnt
);

    lane_code_t         zp0_q, zp1_q;
    logic [WID_LEN-1:0] len_q, cnt_q;

    logic        s1_v, s2_v;
    s1_payload_t s1_q, s1_d;
    logic        s2_adv, s1_adv, acc, last_tag;
    lane_code_t  code0, code1;
    lane_wide_t  w0, w1;
    logic        sat0, sat1;

    assign code0 = io.in_data[WID_DATA_OUT-1:0];
    assign code1 = io.in_data[2*WID_DATA_OUT-1:WID_DATA_OUT];

    assign s2_adv      = !s2_v || io.out_ready;
    assign s1_adv      = s1_v && s2_adv;
    assign io.in_ready = !s1_v || s2_adv;
    assign acc         = io.in_valid && io.in_ready;
    assign last_tag    = (cnt_q == len_q - WID_LEN'(1));

    always_comb begin
        s1_d      = '0;
        s1_d.d0   = lane_diff_t'(code0) - lane_diff_t'(zp0_q);
        s1_d.d1   = lane_diff_t'(code1) - lane_diff_t'(zp1_q);
        s1_d.last = last_tag;
    end

    // Config and frame counter. A beat accepted together with cfg_we has
    // already been tagged from the old state; the clear still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zp0_q <= '0;
            zp1_q <= '0;
            len_q <= WID_LEN'(1);
            cnt_q <= '0;
        end else if (cfg_we) begin
            zp0_q <= cfg_zp0;
            zp1_q <= cfg_zp1;
            len_q <= (cfg_len == '0) ? WID_LEN'(1) : cfg_len;
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q <= last_tag ? '0 : cnt_q + WID_LEN'(1);
        end
    end

    // S1: zero-point removed. Holds its beat when S2 cannot take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (io.in_ready) begin
            s1_v <= io.in_valid;
            if (acc) s1_q <= s1_d;
        end
    end

    lane_expand_sat u_sat0 (.d(s1_q.d0), .w_out(w0), .sat(sat0));
    lane_expand_sat u_sat1 (.d(s1_q.d1), .w_out(w1), .sat(sat1));

    // S2: registers drive the outputs directly and only change when S2 advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v        <= 1'b0;
            io.out_data <= '0;
            io.out_sat  <= '0;
            io.out_last <= 1'b0;
        end else begin
            if (s2_adv) s2_v <= s1_v;
            if (s1_adv) begin
                io.out_data <= {w1, w0};
                io.out_sat  <= {sat1, sat0};
                io.out_last <= s1_q.last;
            end
        end
    end

    assign io.out_valid = s2_v;

`ifdef DEQUANT_STATS_EN
    logic [1:0]  zero_inc;
    logic [32:0] zero_sum;

    assign zero_inc = {1'b0, (code0 == '0)} + {1'b0, (code1 == '0)};
    assign zero_sum = {1'b0, zero_cnt} + {31'b0, zero_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      zero_cnt <= '0;
        else if (cfg_we) zero_cnt <= '0;
        else if (acc)    zero_cnt <= zero_sum[32] ? '1 : zero_sum[31:0];
    end
`else
    assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_lane_dequant_expand.sv
// Purpose: randomized and directed stimulus for lane_dequant_expand, checked against a queue-based reference model.
// Latency: expects 2-cycle accept-to-output when out_ready is held high.
// Backpressure: random out_ready stalls; held outputs must stay stable.
module tb_lane_dequant_expand;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_zp0, cfg_zp1;
    logic [15:0] cfg_len;
    logic [31:0] zero_cnt;

    lane_dequant_expand_if bus ();

    lane_dequant_expand dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io      (bus),
        .cfg_we  (cfg_we),
        .cfg_zp0 (cfg_zp0),
        .cfg_zp1 (cfg_zp1),
        .cfg_len (cfg_len),
        .zero_cnt(zero_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [66:0] v;   // {last, sat[1:0], data[63:0]}
        int          t;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q[$];

    // reference state
    logic [7:0]  m_zp0, m_zp1;
    int          m_len, m_cnt;
    longint      m_zero;

    logic        lat_mode;
    logic        stalled_prev;
    logic [66:0] held;
    logic        last_acc;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Plain arithmetic: (code - zp) * 2^24, clamped to signed 32-bit.
    function automatic logic [32:0] ref_lane(input logic [7:0] code, input logic [7:0] zp);
        longint     d, w;
        logic [63:0] wb;
        d  = longint'($signed(code)) - longint'($signed(zp));
        w  = d * 64'sd16777216;
        if (w > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
        else if (w < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        wb = w;
        return {1'b0, wb[31:0]};
    endfunction

    task automatic model_reset();
        q.delete();
        m_zp0 = 8'h00; m_zp1 = 8'h00; m_len = 1; m_cnt = 0; m_zero = 0;
        stalled_prev = 1'b0;
    endtask

    task automatic sample();
        logic        acc, fire, lst;
        logic [66:0] cur;
        logic [32:0] l0, l1;
        exp_t        e;
        acc  = bus.in_valid && bus.in_ready;
        fire = bus.out_valid && bus.out_ready;
        cur  = {bus.out_last, bus.out_sat, bus.out_data};
        check("zero_cnt", 96'(zero_cnt), 96'(m_zero));
        if (stalled_prev) check("hold", 96'(cur), 96'(held));
        if (fire) begin
            if (q.size() == 0) begin
                check("spurious_beat", 96'(1), 96'(0));
            end else begin
                e = q.pop_front();
                check("beat", 96'(cur), 96'(e.v));
                if (lat_mode) check("latency", 96'(cyc - e.t), 96'(2));
            end
        end
        stalled_prev = bus.out_valid && !bus.out_ready;
        held         = cur;
        last_acc     = acc;
        if (acc) begin
            lst = (m_cnt == m_len - 1);
            m_cnt = lst ? 0 : m_cnt + 1;
            l0 = ref_lane(bus.in_data[7:0],  m_zp0);
            l1 = ref_lane(bus.in_data[15:8], m_zp1);
            e.v = {lst, l1[32], l0[32], l1[31:0], l0[31:0]};
            e.t = cyc;
            q.push_back(e);
`ifdef DEQUANT_STATS_EN
            if (bus.in_data[7:0]  == 8'h00) m_zero++;
            if (bus.in_data[15:8] == 8'h00) m_zero++;
            if (m_zero > 64'hFFFF_FFFF) m_zero = 64'hFFFF_FFFF;
`endif
        end
        if (cfg_we) begin
            m_zp0 = cfg_zp0; m_zp1 = cfg_zp1;
            m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
            m_cnt = 0; m_zero = 0;
        end
        cyc++;
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic ordy, input logic we);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        cfg_we        = we;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] z0, input logic [7:0] z1, input logic [15:0] ln);
        cfg_zp0 = z0; cfg_zp1 = z1; cfg_len = ln;
        step(1'b0, 16'h0, 1'b1, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 40) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            n++;
        end
        check("drain_empty", 96'(q.size()), 96'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, 96'({bus.out_valid, bus.out_last, bus.out_sat, bus.out_data}), 96'(0));
        check("rst_zero_cnt", 96'(zero_cnt), 96'(0));
        check("rst_in_ready", 96'(bus.in_ready), 96'(1));
    endtask

    initial begin
        logic [15:0] cur_d;
        int          accepted, budget;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_zp0 = '0; cfg_zp1 = '0; cfg_len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        lat_mode = 1'b0; last_acc = 1'b0; held = '0;
        model_reset();
        #12;
        check_reset_state("rst_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic expansion, frame of 4, latency with no stalls
        set_cfg(8'h00, 8'h00, 16'd4);
        lat_mode = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 16'hFF01, 1'b1, 1'b0);
        drain();

        // saturation at both rails, then exact most-negative without saturation
        set_cfg(8'h80, 8'h7F, 16'd1);
        step(1'b1, 16'h807F, 1'b1, 1'b0);
        set_cfg(8'h00, 8'h00, 16'd1);
        step(1'b1, 16'h8080, 1'b1, 1'b0);
        step(1'b1, 16'h7F7F, 1'b1, 1'b0);
        drain();
        lat_mode = 1'b0;

        // random stream with random backpressure
        set_cfg(8'($urandom), 8'($urandom), 16'($urandom_range(1, 7)));
        cur_d = 16'($urandom);
        accepted = 0; budget = 0;
        while (accepted < 200 && budget < 2000) begin
            step(1'b1, cur_d, 1'($urandom_range(0, 1)), 1'b0);
            if (last_acc) begin
                accepted++;
                cur_d = 16'($urandom);
                if ($urandom_range(0, 7) == 0) cur_d[7:0] = 8'h00;
            end
            budget++;
        end
        check("stream_accepts", 96'(accepted), 96'(200));
        drain();

        // config change on the same cycle as an accept: len 3 -> 2
        set_cfg(8'h03, 8'hFD, 16'd3);
        step(1'b1, 16'h1122, 1'b1, 1'b0);
        cfg_zp0 = 8'h10; cfg_zp1 = 8'hF0; cfg_len = 16'd2;
        step(1'b1, 16'h3344, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 16'(i * 16'h0305), 1'b1, 1'b0);
        set_cfg(8'h00, 8'h00, 16'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'(i * 16'h0101), 1'b1, 1'b0);
        drain();

        // reset with two beats in flight
        step(1'b1, 16'h0102, 1'b1, 1'b0);
        step(1'b1, 16'h0304, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 96'(bus.out_valid), 96'(0));
        model_reset();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check_reset_state("midrst_outputs");
        rst_n = 1'b1;
        step(1'b1, 16'h7E05, 1'b1, 1'b0);
        step(1'b1, 16'h0506, 1'b1, 1'b0);
        drain();

        // zero-code statistics
        set_cfg(8'h00, 8'h00, 16'd2);
        step(1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h0500, 1'b1, 1'b0);
        drain();
`ifdef DEQUANT_STATS_EN
        check("zero_cnt_3", 96'(zero_cnt), 96'(3));
`else
        check("zero_cnt_off", 96'(zero_cnt), 96'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
